card_shoe: RTL and testbench

Upstream card source for the ten-and-a-half game controller. It replaces the stateless lookup with a real shoe: it holds a DECK_SIZE-card deck of ranks 1..13, four of each rank per 52 cards. It shuffles the deck with a Fisher-Yates pass driven by a free-running LFSR, then deals cards in order on each pip request, so no card repeats until the next shuffle. Its output `number` feeds the game controller directly; ranks 11..13 are face cards, which the controller scores as half a point.

---
 rtl/card_shoe.sv | 124 ++++++++++++
 tb/tb_card_shoe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/card_shoe.sv
// Card shoe: holds a DECK_SIZE-card deck, Fisher-Yates shuffles it with a free-running
// LFSR, then deals one card per rising edge of pip until the shoe is empty.
module card_shoe #(
  parameter int          DECK_SIZE = 52,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pip,
  input  logic       shuffle,
  output logic [3:0] number,
  output logic       valid,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       empty
);

  typedef enum logic [1:0] {INIT, SHUF, READY} state_t;

  localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);
  localparam logic [5:0] FULL = 6'(DECK_SIZE);

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic        pip_d, shuf_d;
  logic [5:0]  k, i, p;
  logic [3:0]  rank;
  logic [5:0]  mask, r;
  logic [3:0]  deck [DECK_SIZE];

  logic pip_rise, shuf_rise, init_done, accept, shuf_done, deal;

  assign pip_rise  = pip & ~pip_d;
  assign shuf_rise = shuffle & ~shuf_d;

  // Smear i rightwards: smallest all-ones mask covering i, so rejection sampling
  // discards fewer than half of the draws.
  assign mask      = i | (i >> 1) | (i >> 2) | (i >> 3) | (i >> 4) | (i >> 5);
  assign r         = lfsr[5:0] & mask;
  assign init_done = (state == INIT) && (k == LAST);
  assign accept    = (state == SHUF) && (r <= i);
  assign shuf_done = accept && (i == 6'd1);
  assign deal      = (state == READY) && !shuf_rise && pip_rise && (cards_left != 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_done) state_nxt = SHUF;
      SHUF:    if (shuf_done) state_nxt = READY;
      READY:   if (shuf_rise) state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    busy  = (state != READY);
    empty = (cards_left == 6'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= LFSR_SEED;
      pip_d      <= 1'b0;
      shuf_d     <= 1'b0;
      k          <= 6'd0;
      rank       <= 4'd1;
      i          <= 6'd0;
      p          <= 6'd0;
      number     <= 4'd0;
      valid      <= 1'b0;
      cards_left <= 6'd0;
    end else begin
      lfsr   <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      pip_d  <= pip;
      shuf_d <= shuffle;
      valid  <= 1'b0;
      case (state)
        INIT: begin
          k    <= init_done ? 6'd0 : k + 6'd1;
          rank <= (rank == 4'd13) ? 4'd1 : rank + 4'd1;
          if (init_done) i <= LAST;
        end
        SHUF: begin
          if (accept) begin
            i <= i - 6'd1;
            if (i == 6'd1) begin
              cards_left <= FULL;
              p          <= 6'd0;
            end
          end
        end
        READY: begin
          if (shuf_rise) begin
            cards_left <= 6'd0;
            k          <= 6'd0;
            rank       <= 4'd1;
          end else if (deal) begin
            number     <= deck[p];
            valid      <= 1'b1;
            p          <= p + 6'd1;
            cards_left <= cards_left - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Deck contents carry no reset; INIT rewrites every entry before use.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      deck[k] <= rank;
    end else if (accept) begin
      deck[i] <= deck[r];
      deck[r] <= deck[i];
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: reference Fisher-Yates model predicts shuffle length
// and deal order; vector table covers READY-state edge handling.
module tb_card_shoe;

  logic       clk = 1'b0;
  logic       rst_n, pip, shuffle, pip_b, shuf_b;
  logic [3:0] number_a, number_b;
  logic       valid_a, valid_b, busy_a, busy_b, empty_a, empty_b;
  logic [5:0] cards_left_a, cards_left_b;

  always #5 clk = ~clk;

  card_shoe dut_a (
    .clk(clk), .rst_n(rst_n), .pip(pip), .shuffle(shuffle),
    .number(number_a), .valid(valid_a), .busy(busy_a),
    .cards_left(cards_left_a), .empty(empty_a)
  );

  card_shoe #(.LFSR_SEED(16'h0001)) dut_b (
    .clk(clk), .rst_n(rst_n), .pip(pip_b), .shuffle(shuf_b),
    .number(number_b), .valid(valid_b), .busy(busy_b),
    .cards_left(cards_left_b), .empty(empty_b)
  );

  typedef struct {
    logic       pip;
    logic       sh;
    logic       valid;
    logic       busy;
    logic [5:0] cl;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_a [52];
  logic [3:0] exp_b [52];
  logic [3:0] seq_a [52];
  logic [3:0] seq_b [52];
  logic [3:0] run1  [52];
  int steps_a, steps_b;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference shuffle: INIT burns 52 LFSR steps, then one draw per SHUF cycle.
  task automatic model(input logic [15:0] seed, input bit sel, output int steps);
    logic [3:0]  d [52];
    logic [15:0] l;
    logic [3:0]  t;
    int i, m, r;
    for (int k = 0; k < 52; k++) d[k] = 4'((k % 13) + 1);
    l = seed;
    repeat (52) l = lfsr_next(l);
    i = 51;
    steps = 0;
    while (1) begin
      m = 1;
      while (m < i) m = m * 2 + 1;
      r = int'(l[5:0]) & m;
      steps++;
      if (r <= i) begin
        t = d[i]; d[i] = d[r]; d[r] = t;
        if (i == 1) break;
        i--;
      end
      l = lfsr_next(l);
    end
    for (int k = 0; k < 52; k++) begin
      if (sel) exp_b[k] = d[k];
      else     exp_a[k] = d[k];
    end
  endtask

  // Counts posedges until each DUT drops busy; optionally toggles pip/shuffle on dut_a meanwhile.
  task automatic wait_ready(input int toggle_until, output int na, output int nb, output bit saw_valid);
    int n;
    n = 0; na = -1; nb = -1; saw_valid = 0;
    while ((na < 0 || nb < 0) && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (valid_a) saw_valid = 1;
      if (na < 0 && !busy_a) na = n;
      if (nb < 0 && !busy_b) nb = n;
      pip     = (n < toggle_until) && ((n % 4) >= 2);
      shuffle = (n < toggle_until) && ((n % 8) >= 4);
    end
    pip = 0; shuffle = 0;
  endtask

  task automatic deal_all(input bit both);
    for (int k = 0; k < 52; k++) begin
      @(negedge clk);
      pip = 1; pip_b = both;
      @(negedge clk);
      seq_a[k] = number_a;
      chk($sformatf("deal_a%0d", k), int'({valid_a, number_a, cards_left_a}),
          int'({1'b1, exp_a[k], 6'(51 - k)}));
      if (both) begin
        seq_b[k] = number_b;
        chk($sformatf("deal_b%0d", k), int'({valid_b, number_b, cards_left_b}),
            int'({1'b1, exp_b[k], 6'(51 - k)}));
      end
      pip = 0; pip_b = 0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  function automatic int bad_ranks(input bit sel);
    int cnt [14];
    int bad;
    for (int j = 0; j < 14; j++) cnt[j] = 0;
    for (int k = 0; k < 52; k++) begin
      if (sel) cnt[seq_b[k]]++;
      else     cnt[seq_a[k]]++;
    end
    bad = cnt[0];
    for (int j = 1; j <= 13; j++) if (cnt[j] != 4) bad++;
    return bad;
  endfunction

  vec_t vecs [17];

  initial begin
    int na, nb, diff, same;
    bit sv;

    vecs[0] = '{0, 0, 0, 0, 6'd52};
    vecs[1] = '{1, 0, 1, 0, 6'd51};
    for (int j = 2; j <= 10; j++) vecs[j] = '{1, 0, 0, 0, 6'd51};
    vecs[11] = '{0, 0, 0, 0, 6'd51};
    vecs[12] = '{1, 0, 1, 0, 6'd50};
    vecs[13] = '{0, 0, 0, 0, 6'd50};
    vecs[14] = '{1, 1, 0, 1, 6'd0};
    vecs[15] = '{1, 1, 0, 1, 6'd0};
    vecs[16] = '{0, 0, 0, 1, 6'd0};

    model(16'hACE1, 0, steps_a);
    model(16'h0001, 1, steps_b);

    rst_n = 1; pip = 0; shuffle = 0; pip_b = 0; shuf_b = 0;
    #2 rst_n = 0;
    #1 chk("reset", int'({number_a, valid_a, busy_a, cards_left_a, empty_a}),
           int'({4'd0, 1'b0, 1'b1, 6'd0, 1'b1}));
    @(negedge clk) rst_n = 1;

    wait_ready(0, na, nb, sv);
    chk("busy_len_a", na, 52 + steps_a);
    chk("busy_len_b", nb, 52 + steps_b);
    chk("ready_out", int'({number_a, valid_a, cards_left_a, empty_a}),
        int'({4'd0, 1'b0, 6'd52, 1'b0}));

    deal_all(1);
    chk("ranks_a", bad_ranks(0), 0);
    chk("ranks_b", bad_ranks(1), 0);
    diff = 0;
    for (int k = 0; k < 52; k++) if (seq_a[k] != seq_b[k]) diff = 1;
    chk("seed_differs", diff, 1);
    chk("empty_after", int'(empty_a), 1);

    @(negedge clk) pip = 1;
    @(negedge clk);
    chk("pip_on_empty", int'({valid_a, number_a, cards_left_a}),
        int'({1'b0, exp_a[51], 6'd0}));
    pip = 0;
    for (int k = 0; k < 52; k++) run1[k] = seq_a[k];

    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
    wait_ready(0, na, nb, sv);
    chk("busy_len_rerun", na, 52 + steps_a);
    deal_all(0);
    same = 1;
    for (int k = 0; k < 52; k++) if (seq_a[k] != run1[k]) same = 0;
    chk("repeatable", same, 1);

    @(negedge clk) shuffle = 1;
    @(negedge clk);
    chk("shuf_start", int'({valid_a, busy_a, cards_left_a}), int'({1'b0, 1'b1, 6'd0}));
    shuffle = 0;
    wait_ready(0, na, nb, sv);
    chk("reshuffled", int'({na > 0, cards_left_a}), int'({1'b1, 6'd52}));

    @(negedge clk);
    for (int v = 0; v < 17; v++) begin
      pip = vecs[v].pip; shuffle = vecs[v].sh;
      @(negedge clk);
      chk($sformatf("vec%0d", v), int'({valid_a, busy_a, cards_left_a}),
          int'({vecs[v].valid, vecs[v].busy, vecs[v].cl}));
    end
    pip = 0; shuffle = 0;

    // Well inside SHUF of the shuffle started by the vector table.
    repeat (60) @(negedge clk);
    rst_n = 0;
    #1 chk("mid_shuf_reset", int'({number_a, valid_a, busy_a, cards_left_a, empty_a}),
           int'({4'd0, 1'b0, 1'b1, 6'd0, 1'b1}));
    @(negedge clk) rst_n = 1;
    wait_ready(52 + steps_a - 10, na, nb, sv);
    chk("busy_len_ignore", na, 52 + steps_a);
    chk("no_valid_busy", int'(sv), 0);
    chk("ready_after_reset", int'({number_a, valid_a, cards_left_a}),
        int'({4'd0, 1'b0, 6'd52}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
